// File: rtl/led_counter_seq.sv
// Sequencer for the LED up/down counter. It latches a start/end range from
// the board switches, loads the counter, paces it with a count-enable tick,
// watches for the endpoint, and can bounce back and forth between endpoints.
module led_counter_seq #(
    parameter int WIDTH      = 5,
    parameter int TICK_DIV   = 4,
    parameter int HOLD_TICKS = 2,
    parameter int RUN_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_start,
    input  logic [WIDTH-1:0] sw_end,
    input  logic             go,
    input  logic             stop,
    input  logic             mode_bounce,
    input  logic             check,
    input  logic [WIDTH-1:0] counter_out,
    output logic [WIDTH-1:0] start_num,
    output logic [WIDTH-1:0] end_num,
    output logic             up_down,
    output logic             load,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic [RUN_W-1:0] run_count
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0]    HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [RUN_W-1:0] RUN_MAX    = {RUN_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_ENDPT,
        ST_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] start_num_q, start_num_d;
    logic [WIDTH-1:0] end_num_q, end_num_d;
    logic             up_down_q, up_down_d;
    logic             load_q, load_d;
    logic             cnt_en_q, cnt_en_d;
    logic             done_q, done_d;
    logic [RUN_W-1:0] run_count_q, run_count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [PW-1:0]    presc_next;

    // Free-running prescaler step; wraps back to zero after TICK_DIV cycles.
    always_comb begin
        presc_next = '0;
        if (presc_q != PRESC_LAST) begin
            presc_next = presc_q + 1'b1;
        end
    end

    // Next-state and next-output logic; pulses are computed one cycle ahead so
    // every output comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        start_num_d = start_num_q;
        end_num_d   = end_num_q;
        up_down_d   = up_down_q;
        load_d      = 1'b0;
        cnt_en_d    = 1'b0;
        done_d      = 1'b0;
        run_count_d = run_count_q;
        presc_d     = presc_q;
        hold_d      = hold_q;

        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                hold_d  = '0;
                if (go && !stop) begin
                    start_num_d = sw_start;
                    end_num_d   = sw_end;
                    up_down_d   = (sw_end >= sw_start);
                    load_d      = 1'b1;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                presc_d = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                presc_d = presc_next;
                if (check && (counter_out == end_num_q)) begin
                    done_d      = 1'b1;
                    run_count_d = (run_count_q == RUN_MAX) ? run_count_q : run_count_q + 1'b1;
                    state_d     = ST_ENDPT;
                end else begin
                    cnt_en_d = (presc_next == PRESC_LAST);
                end
            end
            ST_ENDPT: begin
                presc_d = presc_next;
                hold_d  = '0;
                state_d = mode_bounce ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                presc_d = presc_next;
                if (presc_q == PRESC_LAST) begin
                    if (hold_q == HOLD_LAST) begin
                        start_num_d = end_num_q;
                        end_num_d   = start_num_q;
                        up_down_d   = ~up_down_q;
                        load_d      = 1'b1;
                        state_d     = ST_LOAD;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (stop && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            start_num_d = start_num_q;
            end_num_d   = end_num_q;
            up_down_d   = up_down_q;
            load_d      = 1'b0;
            cnt_en_d    = 1'b0;
            done_d      = 1'b0;
            run_count_d = run_count_q;
            presc_d     = '0;
            hold_d      = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            start_num_q <= '0;
            end_num_q   <= '0;
            up_down_q   <= 1'b1;
            load_q      <= 1'b0;
            cnt_en_q    <= 1'b0;
            done_q      <= 1'b0;
            run_count_q <= '0;
            presc_q     <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            start_num_q <= start_num_d;
            end_num_q   <= end_num_d;
            up_down_q   <= up_down_d;
            load_q      <= load_d;
            cnt_en_q    <= cnt_en_d;
            done_q      <= done_d;
            run_count_q <= run_count_d;
            presc_q     <= presc_d;
            hold_q      <= hold_d;
        end
    end

    assign start_num = start_num_q;
    assign end_num   = end_num_q;
    assign up_down   = up_down_q;
    assign load      = load_q;
    assign cnt_en    = cnt_en_q;
    assign done      = done_q;
    assign run_count = run_count_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
